// File: rtl/regbus_pkg.sv
// regbus_pkg: shared FSM state type, slave ID constant and address-error decode
// for the regbus register slave.
package regbus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } regbus_state_e;

    localparam logic [31:0] REGBUS_SLAVE_ID = 32'h5EB0_0001;

    // Misaligned or past the last register; addresses below the base wrap to huge offsets.
    function automatic logic decode_err(input logic [31:0] offset, input int unsigned num_regs);
        return (offset[1:0] != 2'b00) || ({2'b00, offset[31:2]} >= 32'(num_regs));
    endfunction

endpackage

// File: rtl/regbus_addr_decode.sv
// regbus_addr_decode: combinational byte-address to register-index decode
// with error flag for misaligned or out-of-range accesses.
module regbus_addr_decode
    import regbus_pkg::*;
#(
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          IW        = $clog2(NUM_REGS)
) (
    input  logic [31:0]   paddr_i,
    output logic [IW-1:0] index_o,
    output logic          err_o
);

    logic [31:0] offset;

    assign offset  = paddr_i - BASE_ADDR;
    assign index_o = offset[IW+1:2];
    assign err_o   = decode_err(offset, NUM_REGS);

endmodule

// File: rtl/regbus_reg_slave.sv
// regbus_reg_slave: APB-style register slave with configurable wait states.
// Define REGBUS_SLAVE_ID_REG_EN to make register 0 a read-only ID register.
module regbus_reg_slave
    import regbus_pkg::*;
#(
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [31:0]              paddr,
    input  logic [31:0]              pwdata,
    output logic                     pready,
    output logic [31:0]              prdata,
    output logic                     pslverr,
    output logic [NUM_REGS*32-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_strobe_o
);

    localparam int IW = $clog2(NUM_REGS);
`ifdef REGBUS_SLAVE_ID_REG_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif

    regbus_state_e        state_q;
    logic [3:0]           cnt_q;
    logic [31:0]          addr_q;
    logic                 write_q;
    logic [31:0]          wdata_q;
    logic                 pready_q;
    logic [31:0]          prdata_q;
    logic                 pslverr_q;
    logic [NUM_REGS-1:0]  strobe_q;

    logic [IW-1:0]        idx;
    logic                 dec_err;
    logic                 err_d;
    logic                 commit_d;
    logic [NUM_REGS-1:0]  wr_d;
    logic [31:0]          rdata_d;
    logic [31:0]          regs_v [NUM_REGS];

    regbus_addr_decode #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR),
        .IW        (IW)
    ) u_decode (
        .paddr_i (addr_q),
        .index_o (idx),
        .err_o   (dec_err)
    );

    assign err_d    = dec_err || (ID_EN && write_q && idx == '0);
    assign commit_d = (state_q == ACCESS) && psel && penable && (cnt_q == 4'd0);
    assign wr_d     = (commit_d && write_q && !err_d) ? NUM_REGS'(1) << idx : '0;
    assign rdata_d  = err_d ? 32'd0 : regs_v[idx];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (ID_EN && g == 0) begin : g_id
            assign regs_v[g] = REGBUS_SLAVE_ID;
        end else begin : g_rw
            logic [31:0] r_q;
            always_ff @(posedge clk) begin
                if (!rst_n)      r_q <= '0;
                else if (wr_d[g]) r_q <= wdata_q;
            end
            assign regs_v[g] = r_q;
        end
        assign regs_o[32*g +: 32] = regs_v[g];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            strobe_q  <= '0;
        end else begin
            strobe_q <= wr_d;
            case (state_q)
                IDLE: if (psel && !penable) begin
                    state_q <= ACCESS;
                    cnt_q   <= 4'(WAIT_STATES);
                    addr_q  <= paddr;
                    write_q <= pwrite;
                    wdata_q <= pwdata;
                end
                ACCESS: if (!psel) begin
                    state_q <= IDLE;
                end else if (penable) begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q   <= RESP;
                        pready_q  <= 1'b1;
                        prdata_q  <= rdata_d;
                        pslverr_q <= err_d;
                    end
                end
                RESP: if (!psel) begin
                    state_q   <= IDLE;
                    pready_q  <= 1'b0;
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                end else if (!penable) begin
                    // Back-to-back setup with psel still high starts the next transfer.
                    state_q   <= ACCESS;
                    cnt_q     <= 4'(WAIT_STATES);
                    addr_q    <= paddr;
                    write_q   <= pwrite;
                    wdata_q   <= pwdata;
                    pready_q  <= 1'b0;
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pready      = pready_q;
    assign prdata      = prdata_q;
    assign pslverr     = pslverr_q;
    assign wr_strobe_o = strobe_q;

endmodule

// File: tb/tb_regbus_reg_slave.sv
// tb_regbus_reg_slave: directed-vector bench; one slave with 1 wait state and one
// with 3 wait states share the same bus inputs.
module tb_regbus_reg_slave;

    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] ID   = 32'h5EB0_0001;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            psel = 1'b0;
    logic            penable = 1'b0;
    logic            pwrite = 1'b0;
    logic [31:0]     paddr = '0;
    logic [31:0]     pwdata = '0;
    logic            pready1, pslverr1, pready3, pslverr3;
    logic [31:0]     prdata1, prdata3;
    logic [N*32-1:0] regs1, regs3;
    logic [N-1:0]    strb1, strb3;
    int              n_vec = 0;
    int              n_err = 0;
    int              s1 = 0;
    int              s3 = 0;
    int              edges;
    int              s;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        s1 <= s1 + $countones(strb1);
        s3 <= s3 + $countones(strb3);
    end

    regbus_reg_slave #(.NUM_REGS(N), .WAIT_STATES(1), .BASE_ADDR(BASE)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready1), .prdata(prdata1),
        .pslverr(pslverr1), .regs_o(regs1), .wr_strobe_o(strb1)
    );

    regbus_reg_slave #(.NUM_REGS(N), .WAIT_STATES(3), .BASE_ADDR(BASE)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready3), .prdata(prdata3),
        .pslverr(pslverr3), .regs_o(regs3), .wr_strobe_o(strb3)
    );

    function automatic logic [31:0] r1(input int i);
        return regs1[32*i +: 32];
    endfunction

    function automatic logic [31:0] r3(input int i);
        return regs3[32*i +: 32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setup(input logic wr, input logic [31:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        tick;
    endtask

    // Edges counted from the setup-detection edge inclusive, bounded at 40.
    task automatic access(input int which);
        penable = 1'b1;
        edges = 1;
        do begin
            tick;
            edges++;
        end while (!(which == 3 ? pready3 : pready1) && edges < 40);
    endtask

    task automatic idle;
        psel = 1'b0; penable = 1'b0;
        tick;
    endtask

    initial begin
        @(negedge clk);
        tick; tick;
        chk("rst_pready", {31'd0, pready1}, 32'd0);
        chk("rst_prdata", prdata1, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr1}, 32'd0);
        chk("rst_strobe", {24'd0, strb1}, 32'd0);
        chk("rst_regs_hi", {31'd0, regs1[N*32-1:32] != '0}, 32'd0);
`ifdef REGBUS_SLAVE_ID_REG_EN
        chk("rst_reg0", r1(0), ID);
`else
        chk("rst_reg0", r1(0), 32'd0);
`endif
        rst_n = 1'b1;
        tick;

        setup(1'b1, BASE + 32'd8, 32'hDEAD_BEEF); access(1);
        chk("wr_edges", edges, 32'd3);
        chk("wr_pready", {31'd0, pready1}, 32'd1);
        chk("wr_pslverr", {31'd0, pslverr1}, 32'd0);
        chk("wr_strobe", {24'd0, strb1}, 32'h04);
        chk("wr_reg2", r1(2), 32'hDEAD_BEEF);
        tick;
        chk("wr_strobe_once", {24'd0, strb1}, 32'd0);
        chk("wr_pready_hold", {31'd0, pready1}, 32'd1);
        idle;
        chk("wr_pready_drop", {31'd0, pready1}, 32'd0);

        setup(1'b0, BASE + 32'd8, 32'd0); access(1);
        chk("rd_edges", edges, 32'd3);
        chk("rd_prdata", prdata1, 32'hDEAD_BEEF);
        chk("rd_pslverr", {31'd0, pslverr1}, 32'd0);
        tick;
        chk("rd_prdata_hold", prdata1, 32'hDEAD_BEEF);
        idle;
        chk("rd_prdata_idle", prdata1, 32'd0);

        setup(1'b0, BASE + 32'd32, 32'd0); access(1);
        chk("oor_rd_pslverr", {31'd0, pslverr1}, 32'd1);
        chk("oor_rd_prdata", prdata1, 32'd0);
        idle;
        s = s1;
        setup(1'b1, BASE + 32'd6, 32'hFFFF_FFFF); access(1);
        chk("mis_wr_pslverr", {31'd0, pslverr1}, 32'd1);
        idle;
        chk("mis_wr_strobes", s1 - s, 32'd0);
        chk("mis_wr_reg1", r1(1), 32'd0);
        setup(1'b0, BASE - 32'd4, 32'd0); access(1);
        chk("wrap_rd_pslverr", {31'd0, pslverr1}, 32'd1);
        idle;

        s = s1;
        setup(1'b1, BASE + 32'd12, 32'd1); access(1);
        setup(1'b1, BASE + 32'd16, 32'd2);
        chk("b2b_pready_low", {31'd0, pready1}, 32'd0);
        access(1);
        idle;
        chk("b2b_reg3", r1(3), 32'd1);
        chk("b2b_reg4", r1(4), 32'd2);
        chk("b2b_strobes", s1 - s, 32'd2);

        setup(1'b1, BASE + 32'd28, 32'hA5A5_5A5A); access(1);
        chk("last_wr_pslverr", {31'd0, pslverr1}, 32'd0);
        idle;
        setup(1'b0, BASE + 32'd28, 32'd0); access(1);
        chk("last_rd_prdata", prdata1, 32'hA5A5_5A5A);
        idle;

        s = s1;
        setup(1'b1, BASE, 32'h1234_5678); access(1);
`ifdef REGBUS_SLAVE_ID_REG_EN
        chk("id_wr_pslverr", {31'd0, pslverr1}, 32'd1);
        idle;
        chk("id_wr_strobes", s1 - s, 32'd0);
        chk("id_reg0", r1(0), ID);
        setup(1'b0, BASE, 32'd0); access(1);
        chk("id_rd_prdata", prdata1, ID);
`else
        chk("r0_wr_pslverr", {31'd0, pslverr1}, 32'd0);
        idle;
        chk("r0_wr_strobes", s1 - s, 32'd1);
        chk("r0_reg0", r1(0), 32'h1234_5678);
        setup(1'b0, BASE, 32'd0); access(1);
        chk("r0_rd_prdata", prdata1, 32'h1234_5678);
`endif
        idle;

        s = s3;
        setup(1'b1, BASE + 32'd20, 32'h0000_CAFE);
        penable = 1'b1;
        tick;
        psel = 1'b0; penable = 1'b0;
        tick;
        chk("abort_reg5_w3", r3(5), 32'd0);
        chk("abort_reg5_w1", r1(5), 32'd0);
        chk("abort_strobes", s3 - s, 32'd0);
        chk("abort_pready", {31'd0, pready3}, 32'd0);

        setup(1'b1, BASE + 32'd24, 32'd77);
        penable = 1'b1;
        tick; tick; tick;
        rst_n = 1'b0;
        tick;
        chk("rst_access_reg6", r3(6), 32'd0);
        rst_n = 1'b1;
        idle;

        setup(1'b1, BASE + 32'd24, 32'h0000_00AA); access(3);
        chk("w3_edges", edges, 32'd5);
        chk("w3_reg6", r3(6), 32'h0000_00AA);
        idle;
        setup(1'b0, BASE + 32'd24, 32'd0); access(3);
        chk("w3_rd_prdata", prdata3, 32'h0000_00AA);
        rst_n = 1'b0;
        tick;
        chk("rst_resp_pready", {31'd0, pready3}, 32'd0);
        chk("rst_resp_prdata", prdata3, 32'd0);
        chk("rst_resp_pslverr", {31'd0, pslverr3}, 32'd0);
        chk("rst_resp_strobe", {24'd0, strb3}, 32'd0);
        chk("rst_resp_regs3", {31'd0, regs3[N*32-1:32] != '0}, 32'd0);
        chk("rst_resp_regs1", {31'd0, regs1[N*32-1:32] != '0}, 32'd0);
        idle;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regbus_reg_slave.md
REGBUS_REG_SLAVE -- requirements
Module: regbus_reg_slave

Interface
REQ-001 Parameter NUM_REGS, 8, number of 32-bit registers (2..64).
REQ-002 Parameter WAIT_STATES, 1, access-phase wait cycles before pready (0..15).
REQ-003 Parameter BASE_ADDR, 32'h0000_0000, byte address of register 0.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 psel  input  1  peripheral select.
REQ-007 penable  input  1  access-phase enable.
REQ-008 pwrite  input  1  1=write, 0=read.
REQ-009 paddr  input  32  byte address.
REQ-010 pwdata  input  32  write data.
REQ-011 pready  output  1  transfer complete, registered.
REQ-012 prdata  output  32  read data, registered.
REQ-013 pslverr  output  1  transfer error, registered.
REQ-014 regs_o  output  NUM_REGS*32  current register contents, reg i at bits [32*i+31:32*i].
REQ-015 wr_strobe_o  output  NUM_REGS  one-cycle pulse on the cycle register i is written.

Function
REQ-016 FSM states IDLE, ACCESS, RESP; the state register and all outputs update only on rising clk.
REQ-017 IDLE: psel=1 and penable=0 sampled -> ACCESS; wait counter loaded with WAIT_STATES; paddr/pwrite/pwdata captured.
REQ-018 ACCESS: psel=1, penable=1, counter>0 -> decrement, pready stays 0.
REQ-019 ACCESS: psel=1, penable=1, counter=0 -> RESP; pready<=1, prdata/pslverr<=result; a valid write commits this edge.
REQ-020 With WAIT_STATES=W, pready rises at the (W+2)th edge after the setup-detection edge.
REQ-021 ACCESS: psel=0 sampled -> IDLE, no write, no strobe, outputs unchanged (abort).
REQ-022 RESP: pready, prdata, and pslverr are held stable while psel=1 and penable=1.
REQ-023 RESP: psel=0 -> IDLE; pready<=0, pslverr<=0, prdata<=0.
REQ-024 RESP: psel=1 and penable=0 (back-to-back, no idle gap) -> treated as a new setup: ACCESS, pready<=0, fields captured.
REQ-025 Decode: offset = paddr - BASE_ADDR (32-bit modular); index = offset[31:2].
REQ-026 Error when paddr[1:0]!=0 or index>=NUM_REGS (includes paddr below BASE_ADDR via wrap-around).
REQ-027 Error write: no register changes and no strobe; pslverr=1.
REQ-028 Error read: prdata=0 and pslverr=1.
REQ-029 Valid read: prdata=register[index] as of the commit edge; pslverr=0.
REQ-030 Valid write: register[index]<=pwdata captured at setup; wr_strobe_o[index]=1 for exactly one cycle; pslverr=0.
REQ-031 Exactly one register write per completed transfer, however long RESP is held.
REQ-032 penable=1 sampled in IDLE without a preceding setup is ignored.

Reset
REQ-033 rst_n=0 at a rising edge: state=IDLE, counter=0, pready=0, prdata=0, pslverr=0, wr_strobe_o=0, all registers=0.
REQ-034 Reset asserted mid-transfer (ACCESS or RESP) aborts the transfer; no write commits on that edge.

Configuration
REQ-035 Macro REGBUS_SLAVE_ID_REG_EN defined: register 0 is read-only and reads the package constant REGBUS_SLAVE_ID.
REQ-036 Macro REGBUS_SLAVE_ID_REG_EN defined: a write to register 0 gives pslverr=1, no change, and no strobe; its regs_o slice equals REGBUS_SLAVE_ID.
REQ-037 Macro REGBUS_SLAVE_ID_REG_EN undefined: register 0 is an ordinary read/write register.

Structure
REQ-038 Shared package regbus_pkg holds the FSM state enum, REGBUS_SLAVE_ID (32'h5EB0_0001), and the error-decode function.
REQ-039 One sub-module, regbus_addr_decode, is combinational: paddr, BASE_ADDR, NUM_REGS -> index, err.

Verification
REQ-040 Write 32'hDEAD_BEEF to BASE_ADDR+8, WAIT_STATES=1 -> pready after 3 edges; reg2 updated; wr_strobe_o=8'b0000_0100 for one cycle; pslverr=0.
REQ-041 Read BASE_ADDR+8 after that write -> prdata=32'hDEAD_BEEF, pslverr=0, held until psel drops.
REQ-042 Read BASE_ADDR+32 with NUM_REGS=8, then write BASE_ADDR+6 -> both pslverr=1; read prdata=0; no strobe.
REQ-043 Back-to-back writes 1,2 to regs 3 and 4 with psel never low -> both commit, one strobe each.
REQ-044 Drop psel in ACCESS with WAIT_STATES=3, then rst_n=0 during RESP -> no write on abort; all outputs 0 after the reset edge.
REQ-045 With REGBUS_SLAVE_ID_REG_EN: read reg0 -> 32'h5EB0_0001; write reg0 -> pslverr=1, value unchanged.
